exp6_controle_exibicao: RTL and testbench



---
 rtl/exp6_controle_exibicao_if.sv | 53 +++++
 rtl/exp6_controle_exibicao.sv | 160 ++++++++++++++++
 tb/tb_exp6_controle_exibicao.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/exp6_controle_exibicao_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exp6_controle_exibicao_if                                     |
// | Purpose  : Bundles the signals between the game controller, the jogada   |
// |            memory and the LED playback sequencer.                        |
// | Signals  : iniciar_exibicao - start request                              |
// |            cancelar         - synchronous abort                          |
// |            limite[3:0]      - index of the last address to show          |
// |            dado_memoria[3:0]- memory read data at endereco               |
// |            endereco[3:0]    - address being displayed                    |
// |            leds[3:0]        - registered LED pattern                     |
// |            exibindo         - playback in progress                       |
// |            pronto_exibicao  - one-cycle done pulse                       |
// |            db_estado[3:0]   - state code for a hexa7seg display          |
// | Modports : master - controller/memory side, slave - sequencer side       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface exp6_controle_exibicao_if;
   logic       iniciar_exibicao;
   logic       cancelar;
   logic [3:0] limite;
   logic [3:0] dado_memoria;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto_exibicao;
   logic [3:0] db_estado;

   modport master (
      output iniciar_exibicao,
      output cancelar,
      output limite,
      output dado_memoria,
      input  endereco,
      input  leds,
      input  exibindo,
      input  pronto_exibicao,
      input  db_estado
   );

   modport slave (
      input  iniciar_exibicao,
      input  cancelar,
      input  limite,
      input  dado_memoria,
      output endereco,
      output leds,
      output exibindo,
      output pronto_exibicao,
      output db_estado
   );
endinterface
`default_nettype wire

// File: rtl/exp6_controle_exibicao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exp6_controle_exibicao                                        |
// | Purpose  : Plays back the stored jogada sequence on the LEDs. Walks the  |
// |            memory address from 0 up to a captured limit, lights each     |
// |            value for T_ON cycles followed by a T_OFF blank gap, then     |
// |            pulses pronto_exibicao for one cycle.                         |
// | Params   : T_ON  - cycles each value stays lit (>= 1)                    |
// |            T_OFF - cycles of blank gap after each value (>= 1)           |
// | Ports    : clock - system clock, rising edge                             |
// |            reset - asynchronous, active-high                             |
// |            bus   - exp6_controle_exibicao_if.slave (start/abort/limit in,|
// |                    memory data in, address/leds/status out)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exp6_controle_exibicao #(
   parameter int T_ON  = 1000,
   parameter int T_OFF = 500
) (
   input  wire logic                      clock,
   input  wire logic                      reset,
   exp6_controle_exibicao_if.slave        bus
);

   // The timer only ever has to hold max(T_ON, T_OFF) - 1.
   localparam int T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
   localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      LIGA    = 3'd2,
      DESLIGA = 3'd3,
      PROXIMO = 3'd4,
      FIM     = 3'd5
   } state_t;

   state_t               state;
   logic [3:0]           limite_reg;
   logic [3:0]           endereco_reg;
   logic [3:0]           leds_reg;
   logic [TIMER_W-1:0]   timer;
   // {exibindo, pronto_exibicao, db_estado}, loaded together with the next
   // state so that the status outputs are registered and glitch-free.
   logic [5:0]           saida;

   function automatic logic [5:0] saidas_de(input state_t s);
      logic exib;
      logic pronto;
      exib   = (s != INICIAL) && (s != FIM);
      pronto = (s == FIM);
      return {exib, pronto, 1'b0, s};
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= INICIAL;
         limite_reg   <= 4'd0;
         endereco_reg <= 4'd0;
         leds_reg     <= 4'd0;
         timer        <= '0;
         saida        <= 6'd0;
      end else if (bus.cancelar) begin
         // Abort wins over everything, including a start request.
         state        <= INICIAL;
         endereco_reg <= 4'd0;
         leds_reg     <= 4'd0;
         timer        <= '0;
         saida        <= saidas_de(INICIAL);
      end else begin
         case (state)
            INICIAL: begin
               endereco_reg <= 4'd0;
               leds_reg     <= 4'd0;
               timer        <= '0;
               if (bus.iniciar_exibicao) begin
                  limite_reg <= bus.limite;
                  state      <= PREPARA;
                  saida      <= saidas_de(PREPARA);
               end
            end

            PREPARA: begin
               // Address 0 has been stable since INICIAL, so the read
               // data is valid to sample here.
               endereco_reg <= 4'd0;
               timer        <= '0;
               leds_reg     <= bus.dado_memoria;
               state        <= LIGA;
               saida        <= saidas_de(LIGA);
            end

            LIGA: begin
               if (timer == ON_LAST) begin
                  timer    <= '0;
                  leds_reg <= 4'd0;
                  state    <= DESLIGA;
                  saida    <= saidas_de(DESLIGA);
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            DESLIGA: begin
               if (timer == OFF_LAST) begin
                  timer <= '0;
                  if (endereco_reg == limite_reg) begin
                     state <= FIM;
                     saida <= saidas_de(FIM);
                  end else begin
                     // Cannot wrap: limite_reg tops out at 15 and we stop
                     // on equality before incrementing.
                     endereco_reg <= endereco_reg + 4'd1;
                     state        <= PROXIMO;
                     saida        <= saidas_de(PROXIMO);
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            PROXIMO: begin
               // One cycle of settling at the new address before sampling.
               leds_reg <= bus.dado_memoria;
               timer    <= '0;
               state    <= LIGA;
               saida    <= saidas_de(LIGA);
            end

            FIM: begin
               // endereco holds the last shown address until INICIAL.
               endereco_reg <= 4'd0;
               leds_reg     <= 4'd0;
               timer        <= '0;
               state        <= INICIAL;
               saida        <= saidas_de(INICIAL);
            end

            default: begin
               endereco_reg <= 4'd0;
               leds_reg     <= 4'd0;
               timer        <= '0;
               state        <= INICIAL;
               saida        <= saidas_de(INICIAL);
            end
         endcase
      end
   end

   assign bus.endereco        = endereco_reg;
   assign bus.leds            = leds_reg;
   assign bus.exibindo        = saida[5];
   assign bus.pronto_exibicao = saida[4];
   assign bus.db_estado       = saida[3:0];

endmodule
`default_nettype wire

// File: tb/tb_exp6_controle_exibicao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exp6_controle_exibicao                                     |
// | Purpose  : Scoreboard bench for exp6_controle_exibicao. Each started     |
// |            playback pushes its expected cycle-by-cycle output trace,     |
// |            built from the playback timing rules; a monitor pops and      |
// |            compares one entry per cycle, expecting idle when empty.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exp6_controle_exibicao;

   localparam int T_ON  = 4;
   localparam int T_OFF = 2;

   typedef struct packed {
      logic [3:0] leds;
      logic [3:0] endereco;
      logic [3:0] db;
      logic       exibindo;
      logic       pronto;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] mem [16];
   exp_t       q [$];
   int         checks = 0;
   int         errors = 0;
   int         pronto_seen = 0;

   exp6_controle_exibicao_if bus ();

   exp6_controle_exibicao #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Combinational memory read.
   assign bus.dado_memoria = mem[bus.endereco];

   function automatic exp_t mk(input logic [3:0] l, input logic [3:0] e,
                               input logic [3:0] d, input logic x,
                               input logic p);
      exp_t r;
      r.leds = l; r.endereco = e; r.db = d; r.exibindo = x; r.pronto = p;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Expected trace from PREPARA entry: PREPARA, then per address T_ON lit
   // cycles and T_OFF blank cycles, a PROXIMO between addresses, then FIM.
   task automatic push_trace(input int lim);
      q.push_back(mk(4'd0, 4'd0, 4'd1, 1'b1, 1'b0));
      for (int i = 0; i <= lim; i++) begin
         for (int c = 0; c < T_ON; c++)
            q.push_back(mk(mem[i], 4'(i), 4'd2, 1'b1, 1'b0));
         for (int c = 0; c < T_OFF; c++)
            q.push_back(mk(4'd0, 4'(i), 4'd3, 1'b1, 1'b0));
         if (i < lim)
            q.push_back(mk(4'd0, 4'(i + 1), 4'd4, 1'b1, 1'b0));
      end
      q.push_back(mk(4'd0, 4'(lim), 4'd5, 1'b0, 1'b1));
   endtask

   // Monitor: one comparison per cycle, away from the active edge.
   always @(negedge clock) begin
      exp_t e;
      exp_t a;
      if (q.size() > 0) e = q.pop_front();
      else              e = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      a = mk(bus.leds, bus.endereco, bus.db_estado, bus.exibindo,
             bus.pronto_exibicao);
      if (bus.pronto_exibicao === 1'b1) pronto_seen++;
      check("cycle_trace{leds,end,db,exib,pronto}", 32'(a), 32'(e));
   end

   task automatic start_run(input int lim);
      @(negedge clock);
      bus.limite           = 4'(lim);
      bus.iniciar_exibicao = 1'b1;
      @(posedge clock);
      #1;
      bus.iniciar_exibicao = 1'b0;
      push_trace(lim);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 5000) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL wait_idle: %0d entries left, expected 0", q.size());
         q.delete();
      end
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_leds"},     32'(bus.leds),            32'd0);
      check({name, "_endereco"}, 32'(bus.endereco),        32'd0);
      check({name, "_db"},       32'(bus.db_estado),       32'd0);
      check({name, "_exib"},     32'(bus.exibindo),        32'd0);
      check({name, "_pronto"},   32'(bus.pronto_exibicao), 32'd0);
   endtask

   initial begin
      int p0;
      bus.iniciar_exibicao = 1'b0;
      bus.cancelar         = 1'b0;
      bus.limite           = 4'd0;
      for (int i = 0; i < 16; i++) mem[i] = 4'd0;

      repeat (3) @(posedge clock);
      #2;
      check_outputs_zero("reset_state");
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Directed: memory {1,2,4}, limite=2.
      mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
      p0 = pronto_seen;
      start_run(2);
      wait_idle();
      check("pronto_count_lim2", 32'(pronto_seen - p0), 32'd1);

      // limite=0: one value, no PROXIMO.
      mem[0] = 4'd9;
      start_run(0);
      wait_idle();

      // limite=15 with memory = address.
      for (int i = 0; i < 16; i++) mem[i] = 4'(i);
      p0 = pronto_seen;
      start_run(15);
      wait_idle();
      check("pronto_count_lim15", 32'(pronto_seen - p0), 32'd1);

      // Asynchronous reset in the middle of LIGA.
      mem[0] = 4'd7; mem[1] = 4'd3;
      p0 = pronto_seen;
      start_run(1);
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      q.delete();
      #1;
      check_outputs_zero("async_reset");
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("pronto_after_reset", 32'(pronto_seen - p0), 32'd0);

      // Cancel during the second DESLIGA, then restart from address 0.
      mem[0] = 4'd5; mem[1] = 4'd6; mem[2] = 4'd8;
      p0 = pronto_seen;
      start_run(2);
      repeat (2 * T_ON + T_OFF + 3) @(negedge clock);
      bus.cancelar = 1'b1;
      @(posedge clock);
      #1;
      bus.cancelar = 1'b0;
      q.delete();
      repeat (3) @(negedge clock);
      check("pronto_after_cancel", 32'(pronto_seen - p0), 32'd0);
      start_run(2);
      wait_idle();

      // iniciar pulsed during LIGA and limite changed mid-run: ignored.
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      start_run(3);
      repeat (3) @(negedge clock);
      bus.iniciar_exibicao = 1'b1;
      bus.limite           = 4'd15;
      @(posedge clock);
      #1;
      bus.iniciar_exibicao = 1'b0;
      bus.limite           = 4'd1;
      wait_idle();

      // Randomized playbacks.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
         start_run(int'($urandom_range(0, 15)));
         repeat (2) @(negedge clock);
         bus.limite = 4'($urandom_range(0, 15));
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
